adder_tree_sched: RTL and testbench



---
 rtl/adder_tree_sched_if.sv | 24 ++
 rtl/adder_tree_sched.sv | 95 +++++++++
 tb/tb_adder_tree_sched.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_tree_sched_if.sv
// adder_tree_sched_if: request/response bundle between two operand producers, the scheduler and one result consumer
interface adder_tree_sched_if #(
  parameter int A_W = 4,
  parameter int C_W = 8
);
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [A_W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [C_W-1:0] req0_c, req0_d, req1_c, req1_d;
  logic rsp_valid;
  logic rsp_ready;
  logic rsp_id;
  logic [A_W:0] sum1;
  logic [C_W:0] sum2;
  logic [C_W+1:0] sum3;
  modport master (
    output req_valid, req0_a, req0_b, req0_c, req0_d, req1_a, req1_b, req1_c, req1_d, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, sum1, sum2, sum3
  );
  modport slave (
    input  req_valid, req0_a, req0_b, req0_c, req0_d, req1_a, req1_b, req1_c, req1_d, rsp_ready,
    output req_ready, rsp_valid, rsp_id, sum1, sum2, sum3
  );
endinterface

// File: rtl/adder_tree_sched.sv
// adder_tree_sched: one shared adder sequenced over a+b, c+d, sum1+sum2 for two round-robin requesters; ADDER_TREE_SCHED_STATS_EN adds per-requester done counters
module adder_tree_sched #(
  parameter int A_W = 4,
  parameter int C_W = 8
) (
  input  logic clk,
  input  logic reset,
  adder_tree_sched_if.slave bus
`ifdef ADDER_TREE_SCHED_STATS_EN
  ,
  output logic [15:0] done_cnt0,
  output logic [15:0] done_cnt1
`endif
);
  localparam int S_W = C_W + 2;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADD1 = 3'd1;
  localparam logic [2:0] ADD2 = 3'd2;
  localparam logic [2:0] ADD3 = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  logic [2:0] state;
  logic rr;
  logic gnt_id;
  logic rsp_hs;
  logic [A_W-1:0] op_a, op_b;
  logic [C_W-1:0] op_c, op_d;
  logic [S_W-1:0] add_x, add_y, add_s;
  assign rsp_hs = bus.rsp_valid && bus.rsp_ready;
  // round-robin grant, offered only while idle; a lone requester always wins
  always_comb begin
    gnt_id = (bus.req_valid == 2'b10) ? 1'b1 : (bus.req_valid == 2'b01) ? 1'b0 : rr;
    bus.req_ready = (state == IDLE && |bus.req_valid) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  end
  // single shared adder, operands steered by the current step
  always_comb begin
    add_x = (state == ADD1) ? S_W'(op_a) : (state == ADD2) ? S_W'(op_c) : S_W'(bus.sum1);
    add_y = (state == ADD1) ? S_W'(op_b) : (state == ADD2) ? S_W'(op_d) : S_W'(bus.sum2);
    add_s = add_x + add_y;
  end
  // sequencer: capture on grant, one addition per step, hold result until consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= 1'b0;
      bus.sum1 <= '0;
      bus.sum2 <= '0;
      bus.sum3 <= '0;
      op_a <= '0;
      op_b <= '0;
      op_c <= '0;
      op_d <= '0;
    end else begin
      if (|bus.req_ready) begin
        state <= ADD1;
        rr <= ~gnt_id;
        bus.rsp_id <= gnt_id;
        op_a <= gnt_id ? bus.req1_a : bus.req0_a;
        op_b <= gnt_id ? bus.req1_b : bus.req0_b;
        op_c <= gnt_id ? bus.req1_c : bus.req0_c;
        op_d <= gnt_id ? bus.req1_d : bus.req0_d;
      end
      if (state == ADD1) begin
        bus.sum1 <= add_s[A_W:0];
        state <= ADD2;
      end
      if (state == ADD2) begin
        bus.sum2 <= add_s[C_W:0];
        state <= ADD3;
      end
      if (state == ADD3) begin
        bus.sum3 <= add_s;
        bus.rsp_valid <= 1'b1;
        state <= DONE;
      end
      if (rsp_hs) begin
        bus.rsp_valid <= 1'b0;
        state <= IDLE;
      end
    end
  end
`ifdef ADDER_TREE_SCHED_STATS_EN
  // saturating count of consumed responses per requester
  always_ff @(posedge clk) begin
    if (reset) begin
      done_cnt0 <= '0;
      done_cnt1 <= '0;
    end else if (rsp_hs) begin
      if (!bus.rsp_id && done_cnt0 != 16'hFFFF) done_cnt0 <= done_cnt0 + 16'd1;
      if (bus.rsp_id && done_cnt1 != 16'hFFFF) done_cnt1 <= done_cnt1 + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_adder_tree_sched.sv
// tb_adder_tree_sched: directed and randomized checks of the shared-adder scheduler against a transaction-level model
module tb_adder_tree_sched;
  localparam int A_W = 4;
  localparam int C_W = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  adder_tree_sched_if #(.A_W(A_W), .C_W(C_W)) bus ();
  logic [1:0] rv = 2'b00;
  logic rdy = 1'b1;
  logic [A_W-1:0] pa [2];
  logic [A_W-1:0] pb [2];
  logic [C_W-1:0] pc [2];
  logic [C_W-1:0] pd [2];
  assign bus.req_valid = rv;
  assign bus.rsp_ready = rdy;
  assign bus.req0_a = pa[0];
  assign bus.req0_b = pb[0];
  assign bus.req0_c = pc[0];
  assign bus.req0_d = pd[0];
  assign bus.req1_a = pa[1];
  assign bus.req1_b = pb[1];
  assign bus.req1_c = pc[1];
  assign bus.req1_d = pd[1];
`ifdef ADDER_TREE_SCHED_STATS_EN
  logic [15:0] done_cnt0, done_cnt1;
`endif
  adder_tree_sched #(.A_W(A_W), .C_W(C_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef ADDER_TREE_SCHED_STATS_EN
    ,
    .done_cnt0(done_cnt0),
    .done_cnt1(done_cnt1)
`endif
  );
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // transaction-level model: a request is either pending, being computed (cnt steps done) or waiting to be consumed
  bit mvalid = 0;
  bit busy = 0;
  bit rr_m = 0;
  bit cur_id = 0;
  int cnt = 0;
  int e1 = 0, e2 = 0, e3 = 0, o1 = 0, o2 = 0, o3 = 0;
  int dc [2] = '{0, 0};
  logic [1:0] acc = 2'b00;
  always @(negedge clk) begin
    logic [1:0] er;
    bit gid;
    gid = (rv == 2'b10) ? 1'b1 : (rv == 2'b01) ? 1'b0 : rr_m;
    er = (!busy && |rv) ? (gid ? 2'b10 : 2'b01) : 2'b00;
    acc = reset ? 2'b00 : (bus.req_ready & rv);
    if (mvalid) begin
      chk("req_ready", 32'(bus.req_ready), 32'(er));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(busy && cnt >= 3));
      if (busy && cnt >= 3) chk("rsp_id", 32'(bus.rsp_id), 32'(cur_id));
      chk("sum1", 32'(bus.sum1), (busy && cnt >= 1) ? e1 : o1);
      chk("sum2", 32'(bus.sum2), (busy && cnt >= 2) ? e2 : o2);
      chk("sum3", 32'(bus.sum3), (busy && cnt >= 3) ? e3 : o3);
`ifdef ADDER_TREE_SCHED_STATS_EN
      chk("done_cnt0", 32'(done_cnt0), dc[0]);
      chk("done_cnt1", 32'(done_cnt1), dc[1]);
`endif
    end
    if (reset) begin
      mvalid = 1;
      busy = 0;
      rr_m = 0;
      cnt = 0;
      o1 = 0;
      o2 = 0;
      o3 = 0;
      dc = '{0, 0};
    end else if (mvalid) begin
      if (busy) begin
        if (cnt >= 3 && rdy) begin
          busy = 0;
          o1 = e1;
          o2 = e2;
          o3 = e3;
          if (dc[cur_id] < 65535) dc[cur_id]++;
        end else if (cnt < 3) cnt++;
      end else if (|rv) begin
        busy = 1;
        cnt = 0;
        cur_id = gid;
        rr_m = !gid;
        e1 = int'(pa[gid]) + int'(pb[gid]);
        e2 = int'(pc[gid]) + int'(pd[gid]);
        e3 = e1 + e2;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (acc[i]) rv[i] = 1'b0;
  endtask
  task automatic issue(input int id, input int a, input int b, input int c, input int d);
    pa[id] = a[A_W-1:0];
    pb[id] = b[A_W-1:0];
    pc[id] = c[C_W-1:0];
    pd[id] = d[C_W-1:0];
    rv[id] = 1'b1;
  endtask
  task automatic wait_rsp(output bit ok);
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.rsp_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask
  task automatic expect_rsp(input string nm, input int id, input int s1, input int s2, input int s3);
    bit ok;
    wait_rsp(ok);
    chk({nm, "_seen"}, 32'(ok), 1);
    if (ok) begin
      chk({nm, "_id"}, 32'(bus.rsp_id), id);
      chk({nm, "_sum1"}, 32'(bus.sum1), s1);
      chk({nm, "_sum2"}, 32'(bus.sum2), s2);
      chk({nm, "_sum3"}, 32'(bus.sum3), s3);
    end
    rdy = 1'b1;
    tick();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      pa[i] = '0;
      pb[i] = '0;
      pc[i] = '0;
      pd[i] = '0;
    end
    do_reset();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_sum3", 32'(bus.sum3), 0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 0);
    issue(0, 0, 3, 1, 255);
    tick();
    chk("t1_accept", 32'(acc), 1);
    n = 0;
    while (!bus.rsp_valid && n < 10) begin
      tick();
      n++;
    end
    chk("t1_latency", n, 3);
    expect_rsp("t1", 0, 3, 256, 259);
    do_reset();
    issue(0, 10, 13, 9, 10);
    issue(1, 15, 15, 109, 37);
    expect_rsp("t2a", 0, 23, 19, 42);
    expect_rsp("t2b", 1, 30, 146, 176);
    issue(1, 15, 15, 255, 255);
    expect_rsp("t3", 1, 30, 510, 540);
    rdy = 1'b0;
    issue(0, 0, 9, 45, 45);
    wait_rsp(ok);
    chk("t4_seen", 32'(ok), 1);
    issue(1, 1, 2, 3, 4);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_hold_valid", 32'(bus.rsp_valid), 1);
      chk("t4_hold_sum1", 32'(bus.sum1), 9);
      chk("t4_hold_sum2", 32'(bus.sum2), 90);
      chk("t4_hold_sum3", 32'(bus.sum3), 99);
      chk("t4_hold_ready", 32'(bus.req_ready), 0);
    end
    rdy = 1'b1;
    tick();
    chk("t4_next_grant", 32'(bus.req_ready), 2);
    expect_rsp("t4b", 1, 3, 7, 10);
    issue(0, 1, 2, 3, 4);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("t5_sum1", 32'(bus.sum1), 0);
    chk("t5_sum2", 32'(bus.sum2), 0);
    chk("t5_sum3", 32'(bus.sum3), 0);
    chk("t5_rsp_id", 32'(bus.rsp_id), 0);
    issue(0, 2, 2, 2, 2);
    issue(1, 3, 3, 3, 3);
    #1;
    chk("t5_grant0", 32'(bus.req_ready), 1);
    expect_rsp("t5a", 0, 4, 4, 8);
    expect_rsp("t5b", 1, 6, 6, 12);
`ifdef ADDER_TREE_SCHED_STATS_EN
    do_reset();
    for (int k = 0; k < 3; k++) begin
      issue(0, k, 1, 2, 3);
      expect_rsp("st0", 0, k + 1, 5, k + 6);
    end
    for (int k = 0; k < 2; k++) begin
      issue(1, 1, k, 4, 4);
      expect_rsp("st1", 1, k + 1, 8, k + 9);
    end
    chk("st_done_cnt0", 32'(done_cnt0), 3);
    chk("st_done_cnt1", 32'(done_cnt1), 2);
`endif
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      rdy = 1'($urandom_range(0, 1));
      for (int i = 0; i < 2; i++) begin
        if (!rv[i]) begin
          if ($urandom_range(0, 2) == 0)
            issue(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end else if ($urandom_range(0, 19) == 0) rv[i] = 1'b0;
      end
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0;
    rv = 2'b00;
    rdy = 1'b1;
    repeat (10) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
